// File: rtl/xbus_pkg.sv
// Shared XBus types, widths and small decode helpers used by the slave responder.
package xbus_pkg;

  localparam int XBUS_AW = 16;
  localparam int XBUS_DW = 8;

  typedef enum logic [1:0] {
    SIZE_1 = 2'b00,
    SIZE_2 = 2'b01,
    SIZE_4 = 2'b10,
    SIZE_8 = 2'b11
  } xbus_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ERR  = 2'd2
  } slave_state_e;

  // Number of bytes moved by a transfer of the given size code.
  function automatic logic [3:0] size_to_bytes(input xbus_size_e size);
    logic [3:0] bytes;
    case (size)
      SIZE_1:  bytes = 4'd1;
      SIZE_2:  bytes = 4'd2;
      SIZE_4:  bytes = 4'd4;
      SIZE_8:  bytes = 4'd8;
      default: bytes = 4'd1;
    endcase
    return bytes;
  endfunction

  // True when exactly one grant line is active (marks an address phase).
  function automatic logic is_onehot16(input logic [15:0] v);
    return (v != 16'h0000) && ((v & (v - 16'h0001)) == 16'h0000);
  endfunction

endpackage

// File: rtl/xbus_slave_mem.sv
// Byte-wide local memory window: one synchronous write port, one asynchronous
// read port. Contents are deliberately not reset so they survive a bus reset.
module xbus_slave_mem
  import xbus_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = XBUS_DW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_r [2**AW];

  // Capture write data at the end of a write transfer cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/xbus_slave_responder.sv
// XBus slave: decodes an address phase, inserts wait states before each byte
// and serves reads from / captures writes into a local byte window. All
// outputs are registered and held at zero while the slave is not selected so
// several slaves can be OR-combined onto the bus.
module xbus_slave_responder
  import xbus_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int          MEM_AW      = 8,
  parameter int          WAIT_STATES = 1
) (
  input  logic               sig_clock,
  input  logic               sig_reset,
  input  logic [15:0]        sig_grant,
  input  logic [XBUS_AW-1:0] sig_addr,
  input  logic [1:0]         sig_size,
  input  logic               sig_read,
  input  logic               sig_write,
  input  logic               sig_bip,
  input  logic [XBUS_DW-1:0] sig_data,
  output logic [XBUS_DW-1:0] sig_data_out,
  output logic               rw,
  output logic               sig_wait,
  output logic               sig_error,
  output logic [15:0]        xfer_count
);

  localparam logic [2:0]        WAIT_INIT_C = 3'(WAIT_STATES);
  localparam logic [16:0]       WIN_SIZE_C  = 17'd1 << MEM_AW;
  localparam logic [MEM_AW-1:0] OFF_ONE_C   = MEM_AW'(1'b1);
  // With no wait states a byte is presented in the very first cycle.
  localparam logic              NO_WAIT_C   = (WAIT_INIT_C == 3'd0);

  slave_state_e       state_r;
  logic [MEM_AW-1:0]  offset_r;
  logic [3:0]         rem_r;
  logic [2:0]         wcnt_r;
  logic               is_read_r;
  logic [XBUS_DW-1:0] data_out_r;
  logic               rw_r;
  logic               wait_r;
  logic               error_r;
  logic [15:0]        xfer_count_r;

  logic [15:0]        addr_diff_s;
  logic               addr_hit_s;
  logic               sel_s;
  logic [MEM_AW-1:0]  addr_off_s;
  logic               xfer_cycle_s;
  logic               burst_err_s;
  logic               mem_we_s;
  logic [MEM_AW-1:0]  rd_addr_s;
  logic [XBUS_DW-1:0] rd_data_s;

  // Unsigned distance from the window base; wraps for addresses below it.
  assign addr_diff_s  = sig_addr - BASE_ADDR;
  assign addr_hit_s   = ({1'b0, addr_diff_s} < WIN_SIZE_C);
  assign addr_off_s   = addr_diff_s[MEM_AW-1:0];
  assign sel_s        = is_onehot16(sig_grant) && (sig_read ^ sig_write) && addr_hit_s;
  assign xfer_cycle_s = (state_r == DATA) && (wcnt_r == 3'd0);
  // bip must be high on every byte but the last and low on the last one.
  assign burst_err_s  = xfer_cycle_s && (sig_bip ? (rem_r == 4'd1) : (rem_r > 4'd1));
  assign mem_we_s     = xfer_cycle_s && !is_read_r;

  // Read address is the offset of the byte presented in the *next* cycle,
  // because read data is registered one edge ahead of its transfer cycle.
  always_comb begin
    rd_addr_s = offset_r;
    case (state_r)
      IDLE: rd_addr_s = addr_off_s;
      DATA: begin
        if (wcnt_r == 3'd0) begin
          rd_addr_s = offset_r + OFF_ONE_C;
        end else begin
          rd_addr_s = offset_r;
        end
      end
      ERR:     rd_addr_s = offset_r;
      default: rd_addr_s = offset_r;
    endcase
  end

  xbus_slave_mem #(
    .AW (MEM_AW),
    .DW (XBUS_DW)
  ) u_mem (
    .clk   (sig_clock),
    .we    (mem_we_s),
    .waddr (offset_r),
    .wdata (sig_data),
    .raddr (rd_addr_s),
    .rdata (rd_data_s)
  );

  // Slave FSM with registered bus outputs computed for the following cycle.
  always_ff @(posedge sig_clock) begin
    if (sig_reset) begin
      state_r      <= IDLE;
      offset_r     <= '0;
      rem_r        <= 4'd0;
      wcnt_r       <= 3'd0;
      is_read_r    <= 1'b0;
      data_out_r   <= 8'h00;
      rw_r         <= 1'b0;
      wait_r       <= 1'b0;
      error_r      <= 1'b0;
      xfer_count_r <= 16'h0000;
    end else begin
      case (state_r)
        IDLE: begin
          error_r <= 1'b0;
          if (sel_s) begin
            state_r    <= DATA;
            offset_r   <= addr_off_s;
            is_read_r  <= sig_read;
            rem_r      <= size_to_bytes(xbus_size_e'(sig_size));
            wcnt_r     <= WAIT_INIT_C;
            wait_r     <= !NO_WAIT_C;
            rw_r       <= sig_read && NO_WAIT_C;
            data_out_r <= (sig_read && NO_WAIT_C) ? rd_data_s : 8'h00;
          end else begin
            wait_r     <= 1'b0;
            rw_r       <= 1'b0;
            data_out_r <= 8'h00;
          end
        end
        DATA: begin
          if (wcnt_r != 3'd0) begin
            wcnt_r     <= wcnt_r - 3'd1;
            wait_r     <= (wcnt_r != 3'd1);
            rw_r       <= is_read_r && (wcnt_r == 3'd1);
            data_out_r <= (is_read_r && (wcnt_r == 3'd1)) ? rd_data_s : 8'h00;
          end else begin
            offset_r <= offset_r + OFF_ONE_C;
            rem_r    <= rem_r - 4'd1;
            wcnt_r   <= WAIT_INIT_C;
            if (burst_err_s) begin
              state_r    <= ERR;
              error_r    <= 1'b1;
              wait_r     <= 1'b0;
              rw_r       <= 1'b0;
              data_out_r <= 8'h00;
            end else if (rem_r == 4'd1) begin
              state_r      <= IDLE;
              xfer_count_r <= xfer_count_r + 16'h0001;
              wait_r       <= 1'b0;
              rw_r         <= 1'b0;
              data_out_r   <= 8'h00;
            end else begin
              wait_r     <= !NO_WAIT_C;
              rw_r       <= is_read_r && NO_WAIT_C;
              data_out_r <= (is_read_r && NO_WAIT_C) ? rd_data_s : 8'h00;
            end
          end
        end
        ERR: begin
          state_r    <= IDLE;
          error_r    <= 1'b0;
          wait_r     <= 1'b0;
          rw_r       <= 1'b0;
          data_out_r <= 8'h00;
        end
        default: begin
          state_r    <= IDLE;
          error_r    <= 1'b0;
          wait_r     <= 1'b0;
          rw_r       <= 1'b0;
          data_out_r <= 8'h00;
        end
      endcase
    end
  end

  assign sig_data_out = data_out_r;
  assign rw           = rw_r;
  assign sig_wait     = wait_r;
  assign sig_error    = error_r;
  assign xfer_count   = xfer_count_r;

endmodule

// File: tb/tb_xbus_slave_responder.sv
// Bench for xbus_slave_responder: two slaves (one with a wait state, one
// without) share the bus in disjoint windows and their outputs are OR-combined.
// Read data and error responses are checked by a scoreboard monitor.
module tb_xbus_slave_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] grant;
  logic [15:0] s_addr;
  logic [1:0]  s_size;
  logic        s_read;
  logic        s_write;
  logic        s_bip;
  logic [7:0]  s_data;

  logic [7:0]  dout1, dout0;
  logic        rw1, rw0, wait1, wait0, err1, err0;
  logic [15:0] cnt1, cnt0;

  logic [7:0]  bus_dout;
  logic        bus_rw, bus_wait, bus_err;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  always #5 clk = ~clk;

  xbus_slave_responder #(.BASE_ADDR(16'h1000), .MEM_AW(4), .WAIT_STATES(1)) u_dut_w1 (
    .sig_clock(clk), .sig_reset(rst), .sig_grant(grant), .sig_addr(s_addr),
    .sig_size(s_size), .sig_read(s_read), .sig_write(s_write), .sig_bip(s_bip),
    .sig_data(s_data), .sig_data_out(dout1), .rw(rw1), .sig_wait(wait1),
    .sig_error(err1), .xfer_count(cnt1)
  );

  xbus_slave_responder #(.BASE_ADDR(16'h2000), .MEM_AW(4), .WAIT_STATES(0)) u_dut_w0 (
    .sig_clock(clk), .sig_reset(rst), .sig_grant(grant), .sig_addr(s_addr),
    .sig_size(s_size), .sig_read(s_read), .sig_write(s_write), .sig_bip(s_bip),
    .sig_data(s_data), .sig_data_out(dout0), .rw(rw0), .sig_wait(wait0),
    .sig_error(err0), .xfer_count(cnt0)
  );

  assign bus_dout = dout1 | dout0;
  assign bus_rw   = rw1 | rw0;
  assign bus_wait = wait1 | wait0;
  assign bus_err  = err1 | err0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_rd(input logic [63:0] d, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.is_err = 1'b0;
      e.data   = d[8*i +: 8];
      exp_q.push_back(e);
    end
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.data   = 8'h00;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every presented read byte or error pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (bus_rw || bus_err) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected", {30'd0, bus_rw, bus_err}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("sb_kind_err", {31'd0, bus_err}, {31'd0, e.is_err});
          if (!e.is_err) check("sb_rdata", {24'd0, bus_dout}, {24'd0, e.data});
        end
      end else begin
        check("sb_idle_data", {24'd0, bus_dout}, 32'd0);
      end
    end
  end

  // One complete transfer; w is the wait-state count of the target slave,
  // bytes are taken LSB first from d, bad drives bip low on byte 0.
  task automatic xfer(input int w, input logic [15:0] addr, input logic [1:0] size,
                      input bit rd, input logic [63:0] d, input bit bad);
    int n;
    int nb;
    n  = 1 << size;
    nb = bad ? 1 : n;
    @(posedge clk); #1;
    grant = 16'h0004; s_addr = addr; s_size = size; s_read = rd; s_write = !rd;
    @(posedge clk); #1;
    grant = 16'h0000; s_read = 1'b0; s_write = 1'b0;
    for (int k = 0; k < nb; k++) begin
      s_data = rd ? 8'h00 : d[8*k +: 8];
      s_bip  = bad ? 1'b0 : (k != n - 1);
      for (int c = 0; c <= w; c++) begin
        @(negedge clk);
        check("wait", {31'd0, bus_wait}, (c < w) ? 32'd1 : 32'd0);
        check("rw", {31'd0, bus_rw}, (rd && (c == w)) ? 32'd1 : 32'd0);
        @(posedge clk); #1;
      end
    end
    s_bip = 1'b0; s_data = 8'h00;
    @(negedge clk);
    check("post_wait", {31'd0, bus_wait}, 32'd0);
    check("post_rw", {31'd0, bus_rw}, 32'd0);
    check("post_error", {31'd0, bus_err}, bad ? 32'd1 : 32'd0);
  endtask

  // Address phase that must not select any slave.
  task automatic no_select(input logic [15:0] g, input logic [15:0] addr, input bit rd, input bit wr);
    @(posedge clk); #1;
    grant = g; s_addr = addr; s_size = 2'b00; s_read = rd; s_write = wr;
    @(posedge clk); #1;
    grant = 16'h0000; s_read = 1'b0; s_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("nosel_wait", {31'd0, bus_wait}, 32'd0);
      check("nosel_rw", {31'd0, bus_rw}, 32'd0);
      check("nosel_error", {31'd0, bus_err}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; grant = 16'h0000; s_addr = 16'h0000; s_size = 2'b00;
    s_read = 1'b0; s_write = 1'b0; s_bip = 1'b0; s_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_wait", {31'd0, bus_wait}, 32'd0);
    check("rst_rw", {31'd0, bus_rw}, 32'd0);
    check("rst_error", {31'd0, bus_err}, 32'd0);
    check("rst_cnt1", {16'd0, cnt1}, 32'd0);
    check("rst_cnt0", {16'd0, cnt0}, 32'd0);

    // Single-byte write then read back, one wait state.
    xfer(1, 16'h1003, 2'b00, 1'b0, 64'hA5, 1'b0);
    check("t1_cnt_wr", {16'd0, cnt1}, 32'd1);
    push_rd(64'hA5, 1);
    xfer(1, 16'h1003, 2'b00, 1'b1, 64'h0, 1'b0);
    check("t1_cnt", {16'd0, cnt1}, 32'd2);

    // 4-byte burst wrapping from offset 14 to offset 1.
    xfer(1, 16'h100E, 2'b10, 1'b0, 64'h44332211, 1'b0);
    push_rd(64'h44332211, 4);
    xfer(1, 16'h100E, 2'b10, 1'b1, 64'h0, 1'b0);
    push_rd(64'h33, 1);
    xfer(1, 16'h1000, 2'b00, 1'b1, 64'h0, 1'b0);
    check("t2_cnt", {16'd0, cnt1}, 32'd5);

    // Zero wait states, 8-byte write and read.
    xfer(0, 16'h2000, 2'b11, 1'b0, 64'h8786858483828180, 1'b0);
    push_rd(64'h8786858483828180, 8);
    xfer(0, 16'h2000, 2'b11, 1'b1, 64'h0, 1'b0);
    check("t3_cnt0", {16'd0, cnt0}, 32'd2);
    check("t3_drain", exp_q.size(), 32'd0);

    // Out of window, both directions, non-onehot grant.
    no_select(16'h0004, 16'h1010, 1'b1, 1'b0);
    no_select(16'h0004, 16'h1003, 1'b1, 1'b1);
    no_select(16'h0003, 16'h1003, 1'b1, 1'b0);
    check("t4_cnt1", {16'd0, cnt1}, 32'd5);
    check("t4_cnt0", {16'd0, cnt0}, 32'd2);

    // Burst error on byte 0 of a 2-byte write.
    xfer(1, 16'h1005, 2'b01, 1'b0, 64'hC2C1, 1'b0);
    check("t5_cnt_pre", {16'd0, cnt1}, 32'd6);
    push_err();
    xfer(1, 16'h1005, 2'b01, 1'b0, 64'h6B5A, 1'b1);
    check("t5_cnt_err", {16'd0, cnt1}, 32'd6);
    push_rd(64'hC25A, 2);
    xfer(1, 16'h1005, 2'b01, 1'b1, 64'h0, 1'b0);
    check("t5_cnt", {16'd0, cnt1}, 32'd7);

    // Reset in the middle of a 4-byte read; memory must survive.
    push_rd(64'h11, 1);
    @(posedge clk); #1;
    grant = 16'h0004; s_addr = 16'h100E; s_size = 2'b10; s_read = 1'b1; s_write = 1'b0;
    @(posedge clk); #1;
    grant = 16'h0000; s_read = 1'b0; s_bip = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; s_bip = 1'b0;
    @(negedge clk);
    check("t6_wait", {31'd0, bus_wait}, 32'd0);
    check("t6_rw", {31'd0, bus_rw}, 32'd0);
    check("t6_error", {31'd0, bus_err}, 32'd0);
    check("t6_dout", {24'd0, bus_dout}, 32'd0);
    check("t6_cnt1", {16'd0, cnt1}, 32'd0);
    check("t6_cnt0", {16'd0, cnt0}, 32'd0);
    push_rd(64'h44332211, 4);
    xfer(1, 16'h100E, 2'b10, 1'b1, 64'h0, 1'b0);
    check("t6_cnt_after", {16'd0, cnt1}, 32'd1);

    check("sb_drain", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xbus_slave_responder.md
# xbus_slave_responder

Synthesizable XBus slave that answers transfers issued by any granted master on the shared `xbus_if` signal set. It decodes the address phase, inserts a programmable number of wait states per byte, and serves reads from or captures writes into a local byte-addressed memory window. It sits alongside the bus arbiter and masters, and is checked by the existing bus monitor assertions.

## Interface
Parameters:
- `BASE_ADDR`, default 16'h0000: first byte address of the window.
- `MEM_AW`, default 8: window size of 2^MEM_AW bytes; legal range 1..16.
- `WAIT_STATES`, default 1: wait cycles inserted before each byte; legal range 0..7.

Ports:
- `sig_clock`  in  1  bus clock; all logic on posedge.
- `sig_reset`  in  1  synchronous, active-high reset.
- `sig_grant`  in  16  arbiter grants; onehot marks the address phase.
- `sig_addr`  in  16  start byte address.
- `sig_size`  in  2  00=1, 01=2, 10=4, 11=8 bytes.
- `sig_read`, `sig_write`  in  1 each  transfer direction.
- `sig_bip`  in  1  burst in progress; high on every byte except the last.
- `sig_data`  in  8  resolved bus data; used for write capture.
- `sig_data_out`  out  8  read data.
- `rw`  out  1  read-data drive enable for the interface tristate.
- `sig_wait`  out  1  1 = byte not ready this cycle.
- `sig_error`  out  1  transfer error, valid on the byte-complete cycle.
- `xfer_count`  out  16  completed transfers; wraps.

## Operation
- All outputs are registered. While not selected, every output is 0. This allows an OR-combine with other slaves.
- FSM states are IDLE, DATA and ERR.
- **IDLE**: select when `$onehot(sig_grant)` holds, exactly one of read/write is set, and `sig_addr - BASE_ADDR < 2^MEM_AW` (unsigned, 16-bit).
  - On select, latch the offset, the direction, and `remaining = bytes(sig_size)`.
  - Load `wcnt = WAIT_STATES` and go to DATA.
  - Read and write both set, or an out-of-window address: no select, stay IDLE.
- **DATA**: each byte occupies WAIT_STATES cycles with `sig_wait=1`, then one cycle with `sig_wait=0` (the transfer cycle).
  - Read: `sig_data_out = mem[offset]` and `rw=1` only in the transfer cycle.
  - Write: `mem[offset] <= sig_data` at the end of the transfer cycle.
  - After each byte: offset increments modulo 2^MEM_AW (wraps inside the window), `remaining` decrements, `wcnt` reloads.
  - Last byte transferred: increment `xfer_count` and go to IDLE.
- **Burst check**: in a transfer cycle, if `sig_bip` is low while remaining > 1, or high while remaining == 1:
  - `sig_error=1` in the next cycle;
  - FSM enters ERR for that one cycle, then IDLE;
  - write data for the offending byte is still stored;
  - `xfer_count` is not incremented.
- A grant arriving while in DATA is ignored. The monitor guarantees no overlap.
- Reset mid-transfer: next cycle is IDLE with all outputs 0. Memory contents are retained, not cleared. `xfer_count` returns to 0.

## Timing
- Address phase sampled at edge A. The first data-phase cycle starts at A+1.
- Byte k (0-based) completes in cycle A+1+k·(WAIT_STATES+1)+WAIT_STATES.
- Total data phase is bytes·(WAIT_STATES+1) cycles. No dead cycle is inserted between bytes.
- With WAIT_STATES=0, `sig_wait` stays 0 and each cycle transfers one byte. Read data for byte 0 is fetched at edge A.
- `sig_wait` and `sig_error` are never X after reset. This satisfies the monitor's X/Z data-phase checks.
- Back-to-back: a new address phase is accepted in the first cycle after returning to IDLE.

## Structure
- `xbus_pkg` holds:
  - `xbus_size_e` enum;
  - `size_to_bytes()` function (returns 4-bit);
  - `slave_state_e` {IDLE, DATA, ERR};
  - `XBUS_AW=16`, `XBUS_DW=8`.
- Sub-module `xbus_slave_mem`: 2^MEM_AW × 8 flop array with one write port and one asynchronous read port, no reset.

## Test plan
- Reset, then a 1-byte write of 8'hA5 to BASE_ADDR+3 with WAIT_STATES=1, then a 1-byte read of the same address. Expect `sig_wait` 1,0 in each data phase, read returns A5, `xfer_count`=2.
- 4-byte write of 11,22,33,44 at offset 2^MEM_AW−2, then a 4-byte read of the same. Expect wrap to offsets 0,1, read data 11,22,33,44, 8 data cycles each.
- WAIT_STATES=0, 8-byte read. Expect `sig_wait` stuck at 0, `rw`=1 for 8 consecutive cycles, return to IDLE at A+9.
- Grant to address BASE_ADDR+2^MEM_AW. Expect all outputs 0 and `xfer_count` unchanged. Repeat with read and write both set: same result.
- 2-byte write with `sig_bip` low on byte 0. Expect `sig_error`=1 for one cycle, byte 0 stored, byte 1 not stored, `xfer_count` unchanged.
- Assert `sig_reset` in the middle of a 4-byte read. Expect all outputs 0 the next cycle, memory contents intact on re-read, `xfer_count`=0.
